// File: rtl/copro_sched_pkg.sv
// Shared types and constants for the coprocessor issue scheduler.
package copro_sched_pkg;

    localparam int unsigned ILLEGAL_OPCODE = 0;

    localparam int unsigned SCHED_NR_RGPR = 2;
    localparam int unsigned SCHED_XLEN    = 32;
    localparam int unsigned SCHED_DEPTH   = 4;
    localparam int unsigned SCHED_ID_W    = 4;
    localparam int unsigned SCHED_HART_W  = 1;
    localparam int unsigned SCHED_OPC_W   = 4;

    typedef enum logic [1:0] {IDLE, EXEC, DRAIN, RESULT} sched_state_e;

    typedef struct packed {
        logic [SCHED_OPC_W-1:0]              opcode;
        logic [SCHED_HART_W-1:0]             hartid;
        logic [SCHED_ID_W-1:0]               id;
        logic [4:0]                          rd;
        logic                                we;
        logic [SCHED_NR_RGPR*SCHED_XLEN-1:0] rs;
        logic                                valid;
        logic                                committed;
        logic                                killed;
    } sched_entry_t;

endpackage

// File: rtl/copro_sched_buffer.sv
// In-order circular buffer of issued instructions with associative commit/kill tagging.
module copro_sched_buffer
    import copro_sched_pkg::*;
#(
    parameter int unsigned NrRgprPorts = SCHED_NR_RGPR,
    parameter int unsigned XLEN        = SCHED_XLEN,
    parameter int unsigned Depth       = SCHED_DEPTH,
    parameter int unsigned IdWidth     = SCHED_ID_W,
    parameter int unsigned HartIdWidth = SCHED_HART_W,
    parameter int unsigned OpcodeWidth = SCHED_OPC_W,
    localparam int unsigned PW         = $clog2(Depth),
    localparam int unsigned CW         = $clog2(Depth) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [OpcodeWidth-1:0]      push_opcode_i,
    input  logic [HartIdWidth-1:0]      push_hartid_i,
    input  logic [IdWidth-1:0]          push_id_i,
    input  logic [4:0]                  push_rd_i,
    input  logic                        push_we_i,
    input  logic [NrRgprPorts*XLEN-1:0] push_rs_i,
    input  logic                        commit_valid_i,
    input  logic [IdWidth-1:0]          commit_id_i,
    input  logic                        commit_kill_i,
    input  logic                        pop_i,
    output logic                        head_valid_o,
    output logic                        head_committed_o,
    output logic                        head_killed_o,
    output logic [OpcodeWidth-1:0]      head_opcode_o,
    output logic [HartIdWidth-1:0]      head_hartid_o,
    output logic [IdWidth-1:0]          head_id_o,
    output logic [4:0]                  head_rd_o,
    output logic                        head_we_o,
    output logic [NrRgprPorts*XLEN-1:0] head_rs_o,
    output logic                        full_o,
    output logic [CW-1:0]               count_o
);

    typedef struct packed {
        logic [OpcodeWidth-1:0]      opcode;
        logic [HartIdWidth-1:0]      hartid;
        logic [IdWidth-1:0]          id;
        logic [4:0]                  rd;
        logic                        we;
        logic [NrRgprPorts*XLEN-1:0] rs;
    } payload_t;

    payload_t         mem_q [Depth];
    logic [Depth-1:0] valid_q, committed_q, killed_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop, push_match;

    assign full_o     = (count_q == CW'(Depth));
    assign count_o    = count_q;
    assign do_push    = push_i && !full_o && !flush_i;
    assign do_pop     = pop_i && valid_q[head_q] && !flush_i;
    assign push_match = commit_valid_i && (push_id_i == commit_id_i);

    assign head_valid_o     = valid_q[head_q];
    assign head_committed_o = committed_q[head_q];
    assign head_killed_o    = killed_q[head_q];
    assign head_opcode_o    = mem_q[head_q].opcode;
    assign head_hartid_o    = mem_q[head_q].hartid;
    assign head_id_o        = mem_q[head_q].id;
    assign head_rd_o        = mem_q[head_q].rd;
    assign head_we_o        = mem_q[head_q].we;
    assign head_rs_o        = mem_q[head_q].rs;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= '{opcode: push_opcode_i, hartid: push_hartid_i, id: push_id_i,
                               rd: push_rd_i, we: push_we_i, rs: push_rs_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (flush_i) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (commit_valid_i && valid_q[i] && !committed_q[i] && !killed_q[i] &&
                    mem_q[i].id == commit_id_i) begin
                    if (commit_kill_i) killed_q[i] <= 1'b1;
                    else               committed_q[i] <= 1'b1;
                end
            end
            // The tail slot is never valid while a push is accepted, so this cannot clash with the match above.
            if (do_push) begin
                valid_q[tail_q]     <= 1'b1;
                committed_q[tail_q] <= push_match && !commit_kill_i;
                killed_q[tail_q]    <= push_match && commit_kill_i;
                tail_q              <= tail_q + 1'b1;
            end
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/copro_issue_scheduler.sv
// Buffers decoded offload instructions, awaits commit/kill, and serialises committed ones
// through a single multi-cycle execution unit, returning one result per committed instruction.
module copro_issue_scheduler
    import copro_sched_pkg::*;
#(
    parameter int unsigned NrRgprPorts = SCHED_NR_RGPR,
    parameter int unsigned XLEN        = SCHED_XLEN,
    parameter int unsigned Depth       = SCHED_DEPTH,
    parameter int unsigned IdWidth     = SCHED_ID_W,
    parameter int unsigned HartIdWidth = SCHED_HART_W,
    parameter int unsigned OpcodeWidth = SCHED_OPC_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [OpcodeWidth-1:0]      in_opcode_i,
    input  logic [HartIdWidth-1:0]      in_hartid_i,
    input  logic [IdWidth-1:0]          in_id_i,
    input  logic [4:0]                  in_rd_i,
    input  logic                        in_we_i,
    input  logic [NrRgprPorts*XLEN-1:0] in_rs_i,
    input  logic                        commit_valid_i,
    input  logic [IdWidth-1:0]          commit_id_i,
    input  logic                        commit_kill_i,
    output logic                        exec_valid_o,
    input  logic                        exec_ready_i,
    output logic [OpcodeWidth-1:0]      exec_opcode_o,
    output logic [NrRgprPorts*XLEN-1:0] exec_rs_o,
    input  logic                        exec_done_i,
    input  logic [XLEN-1:0]             exec_result_i,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [HartIdWidth-1:0]      result_hartid_o,
    output logic [IdWidth-1:0]          result_id_o,
    output logic [4:0]                  result_rd_o,
    output logic                        result_we_o,
    output logic [XLEN-1:0]             result_data_o,
    output logic [$clog2(Depth):0]      count_o
);

    sched_state_e                state_q, state_d;
    logic                        full, push, pop, dispatch, capture;
    logic                        head_valid, head_committed, head_killed, head_we;
    logic [OpcodeWidth-1:0]      head_opcode;
    logic [HartIdWidth-1:0]      head_hartid;
    logic [IdWidth-1:0]          head_id;
    logic [4:0]                  head_rd;
    logic [NrRgprPorts*XLEN-1:0] head_rs;

    assign in_ready_o = !full;
    assign push       = in_valid_i && in_ready_o && (in_opcode_i != OpcodeWidth'(ILLEGAL_OPCODE));

    copro_sched_buffer #(
        .NrRgprPorts (NrRgprPorts),
        .XLEN        (XLEN),
        .Depth       (Depth),
        .IdWidth     (IdWidth),
        .HartIdWidth (HartIdWidth),
        .OpcodeWidth (OpcodeWidth)
    ) u_buffer (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .push_i           (push),
        .push_opcode_i    (in_opcode_i),
        .push_hartid_i    (in_hartid_i),
        .push_id_i        (in_id_i),
        .push_rd_i        (in_rd_i),
        .push_we_i        (in_we_i),
        .push_rs_i        (in_rs_i),
        .commit_valid_i   (commit_valid_i),
        .commit_id_i      (commit_id_i),
        .commit_kill_i    (commit_kill_i),
        .pop_i            (pop),
        .head_valid_o     (head_valid),
        .head_committed_o (head_committed),
        .head_killed_o    (head_killed),
        .head_opcode_o    (head_opcode),
        .head_hartid_o    (head_hartid),
        .head_id_o        (head_id),
        .head_rd_o        (head_rd),
        .head_we_o        (head_we),
        .head_rs_o        (head_rs),
        .full_o           (full),
        .count_o          (count_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        dispatch     = 1'b0;
        capture      = 1'b0;
        exec_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                exec_valid_o = head_valid && head_committed;
                // A handshake coinciding with flush has already started the unit, so drain it.
                if (flush_i) begin
                    if (exec_valid_o && exec_ready_i) state_d = DRAIN;
                end else if (head_valid && head_killed) begin
                    pop = 1'b1;
                end else if (exec_valid_o && exec_ready_i) begin
                    pop      = 1'b1;
                    dispatch = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (exec_done_i) begin
                    capture = !flush_i;
                    state_d = flush_i ? IDLE : RESULT;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (exec_done_i) state_d = IDLE;
            end
            RESULT: begin
                if (flush_i || result_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign exec_opcode_o  = exec_valid_o ? head_opcode : '0;
    assign exec_rs_o      = exec_valid_o ? head_rs : '0;
    assign result_valid_o = (state_q == RESULT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_hartid_o <= '0;
            result_id_o     <= '0;
            result_rd_o     <= '0;
            result_we_o     <= 1'b0;
            result_data_o   <= '0;
        end else begin
            if (dispatch) begin
                result_hartid_o <= head_hartid;
                result_id_o     <= head_id;
                result_rd_o     <= head_rd;
                result_we_o     <= head_we;
            end
            if (capture) result_data_o <= result_we_o ? exec_result_i : '0;
        end
    end

    done_only_when_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        exec_done_i |-> (state_q == EXEC || state_q == DRAIN));

endmodule

// File: doc/copro_issue_scheduler.md
Name: copro_issue_scheduler

Overview:
Sequences accepted offloaded instructions from the coprocessor instruction decoder onto a single shared multi-cycle execution unit. Buffers issued instructions in order and waits for each commit/kill decision. Dispatches committed instructions one at a time, drops killed ones without a result, and returns exactly one result transaction per committed instruction. Sits between the instruction decoder and the coprocessor result interface.

Parameters:
NrRgprPorts, 2, number of source register operands carried per instruction (2 or 3)
XLEN, 32, register/result width
Depth, 4, buffer entries (power of two, >=2)
IdWidth, 4, instruction id width
HartIdWidth, 1, hart id width
OpcodeWidth, 4, decoded opcode width (value 0 = ILLEGAL)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
flush_i  in  1  discard all buffered and in-flight work
in_valid_i  in  1  decoded instruction valid (decoder accepted it)
in_ready_o  out  1  buffer can take an entry
in_opcode_i  in  OpcodeWidth  decoded opcode
in_hartid_i  in  HartIdWidth  hart id
in_id_i  in  IdWidth  instruction id
in_rd_i  in  5  destination register
in_we_i  in  1  instruction writes back
in_rs_i  in  NrRgprPorts*XLEN  source operands, rs[0] in LSBs
commit_valid_i  in  1  commit transaction valid
commit_id_i  in  IdWidth  id being committed/killed
commit_kill_i  in  1  1 = kill, 0 = commit
exec_valid_o  out  1  dispatch request to execution unit
exec_ready_i  in  1  execution unit accepts dispatch
exec_opcode_o  out  OpcodeWidth  dispatched opcode
exec_rs_o  out  NrRgprPorts*XLEN  dispatched operands
exec_done_i  in  1  execution unit result valid (one-cycle pulse)
exec_result_i  in  XLEN  execution result
result_valid_o  out  1  result transaction valid
result_ready_i  in  1  core accepts result
result_hartid_o  out  HartIdWidth  result hart id
result_id_o  out  IdWidth  result id
result_rd_o  out  5  result destination
result_we_o  out  1  writeback enable
result_data_o  out  XLEN  result data
count_o  out  $clog2(Depth)+1  occupied entries

Behaviour:
- Reset values: in_ready_o=1, count_o=0, every other output 0. FSM=IDLE. Buffer empty. All flags clear.
- Buffer: in-order circular FIFO. Each entry holds the in_* fields plus valid, committed and killed flags.
- in_ready_o = !full. It does not depend on a same-cycle pop, so there is no combinational path from exec_ready_i.
- Push occurs on in_valid_i && in_ready_o && in_opcode_i!=0. An entry with opcode 0 is ignored.
- Commit: an associative match on valid, undecided entries with id==commit_id_i. The match sets killed when commit_kill_i=1, otherwise committed.
- A commit in the same cycle as the push of that id applies to the pushed entry (bypass).
- A commit for an id with no matching entry is ignored. Ids are unique among in-flight entries.
- FSM IDLE:
  - Head killed: pop, no dispatch, one cycle per killed entry.
  - Head committed: exec_valid_o=1 with head opcode and operands, registered from the buffer.
  - On exec_ready_i: pop, latch hartid/id/rd/we, go to EXEC.
  - Head undecided or buffer empty: stay.
- FSM EXEC: on exec_done_i, capture exec_result_i and go to RESULT.
- FSM RESULT: result_valid_o=1 with all result_* fields held stable. On result_ready_i go to IDLE.
- Every committed instruction produces exactly one result. When we=0, result_we_o=0 and result_data_o=0.
- exec_valid_o and the exec_* fields stay stable until exec_ready_i.
- exec_done_i in IDLE or RESULT is a protocol error: ignored, with an assertion.
- Minimum latency: push and commit in cycle N, exec_valid_o in N+1, exec_ready_i in N+1, exec_done_i at N+2 or later, result_valid_o the cycle after exec_done_i.
- flush_i takes priority over push, commit and pop. It empties the buffer and drops a pending RESULT (go to IDLE).
  - In EXEC, flush goes to DRAIN. DRAIN waits for exec_done_i, then goes to IDLE with no result. No dispatch while in DRAIN.
  - In IDLE, flush deasserts exec_valid_o the next cycle.
- Simultaneous push and pop with the buffer full: the pop happens and the push is refused (in_ready_o was 0).
- Simultaneous push, pop and commit are all honoured. count_o is updated accordingly.
- Pointers wrap modulo Depth. full/empty are derived from count.
- Reset asserted mid-operation returns to reset values immediately (asynchronous).

Decomposition:
- Package copro_sched_pkg:
  - sched_state_e {IDLE, EXEC, DRAIN, RESULT}
  - sched_entry_t struct (opcode, hartid, id, rd, we, rs, valid, committed, killed)
  - ILLEGAL_OPCODE=0
- One sub-module, copro_sched_buffer: the circular FIFO with associative commit/kill tagging, push/pop, flush and count.
- The FSM and result register live in copro_issue_scheduler.

Test Plan:
- Push id=3 (opcode 1, rs={5,7}, we=1, rd=10); commit id=3 same cycle; exec_ready_i=1; exec_done_i two cycles later with result 12 -> result_valid_o with id=3, rd=10, we=1, data=12; held until result_ready_i.
- Push ids 1,2,3; kill id=2; commit ids 1 and 3 -> exactly two exec dispatches (ids 1 then 3) and two results in order; no result for id=2.
- Push 4 entries, none committed -> in_ready_o=0 and count_o=4. A fifth in_valid_i is not accepted. Commit head, dispatch -> in_ready_o=1 the cycle after the pop.
- Head committed, exec_ready_i=0 for 3 cycles -> exec_valid_o held, exec_opcode_o/exec_rs_o stable, no pop.
- Dispatch id=5, then flush_i in EXEC -> DRAIN. Buffer empty. exec_done_i later gives no result_valid_o. Then push id=6, commit -> dispatched normally.
- rst_i asserted in RESULT with result_valid_o=1 -> result_valid_o=0 and count_o=0 immediately; in_ready_o=1.
